// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles.
// Optional `PERIOD_METER_AVG_EN: report the average of every 4 consecutive periods.
module period_meter #(
  parameter int CNT_W       = 28,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overrun,
  output logic             timeout
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("period_meter: SYNC_STAGES must be at least 2");
  end
  if (64'(TIMEOUT_CYC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_chk_timeout
    $error("period_meter: TIMEOUT_CYC does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sdly_q;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   s_s;
  logic                   rise_s;
  logic                   fall_s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
  logic                   hi_seen_q, hi_seen_d;
  logic                   timeout_q, timeout_d;
  logic                   raw_form_s;
  logic [CNT_W-1:0]       raw_per_s;
  logic [CNT_W-1:0]       raw_hi_s;

  logic                   form_q, form_d;
  logic [CNT_W-1:0]       fper_q, fper_d;
  logic [CNT_W-1:0]       fhi_q, fhi_d;

  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       per_q, per_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   ovr_q, ovr_d;
  logic                   sticky_q, sticky_d;

  // Edges are masked until the whole chain holds real samples, so the level
  // present when reset releases never looks like a fresh edge.
  assign s_s    = sync_q[SYNC_STAGES-1];
  assign rise_s = arm_q[SYNC_STAGES] & s_s & ~sdly_q;
  assign fall_s = arm_q[SYNC_STAGES] & ~s_s & sdly_q;

  // Measurement FSM: counter, high-time capture and timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_cap_d   = hi_cap_q;
    hi_seen_d  = hi_seen_q;
    timeout_d  = 1'b0;
    raw_form_s = 1'b0;
    raw_per_s  = cnt_q;
    raw_hi_s   = hi_cap_q;
    case (state_q)
      IDLE: begin
        hi_seen_d = 1'b0;
        if (rise_s) begin
          state_d = MEASURE;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          raw_form_s = 1'b1;
          cnt_d      = {{(CNT_W-1){1'b0}}, 1'b1};
          hi_seen_d  = 1'b0;
        end else if (cnt_q >= TIMEOUT_V) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          hi_cap_d  = '0;
          hi_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (fall_s && !hi_seen_q) begin
            hi_cap_d  = cnt_q;
            hi_seen_d = 1'b1;
          end else begin
            hi_cap_d = hi_cap_q;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        hi_seen_d = 1'b0;
      end
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  logic [CNT_W+1:0] acc_per_q, acc_per_d;
  logic [CNT_W+1:0] acc_hi_q, acc_hi_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W+1:0] sum_per_s;
  logic [CNT_W+1:0] sum_hi_s;

  assign sum_per_s = acc_per_q + {2'b00, raw_per_s};
  assign sum_hi_s  = acc_hi_q + {2'b00, raw_hi_s};

  // Accumulate four raw measurements, emit their truncated mean
  always_comb begin
    acc_per_d = acc_per_q;
    acc_hi_d  = acc_hi_q;
    idx_d     = idx_q;
    form_d    = 1'b0;
    fper_d    = fper_q;
    fhi_d     = fhi_q;
    if (timeout_d) begin
      acc_per_d = '0;
      acc_hi_d  = '0;
      idx_d     = 2'd0;
    end else if (raw_form_s) begin
      if (idx_q == 2'd3) begin
        form_d    = 1'b1;
        fper_d    = CNT_W'(sum_per_s >> 2);
        fhi_d     = CNT_W'(sum_hi_s >> 2);
        acc_per_d = '0;
        acc_hi_d  = '0;
        idx_d     = 2'd0;
      end else begin
        acc_per_d = sum_per_s;
        acc_hi_d  = sum_hi_s;
        idx_d     = idx_q + 2'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_per_q <= '0;
      acc_hi_q  <= '0;
      idx_q     <= 2'd0;
    end else begin
      acc_per_q <= acc_per_d;
      acc_hi_q  <= acc_hi_d;
      idx_q     <= idx_d;
    end
  end
`else
  // Every raw measurement is a result
  always_comb begin
    form_d = raw_form_s;
    if (raw_form_s) begin
      fper_d = raw_per_s;
      fhi_d  = raw_hi_s;
    end else begin
      fper_d = fper_q;
      fhi_d  = fhi_q;
    end
  end
`endif

  // Result delivery: hold while unaccepted, drop and flag results that collide
  always_comb begin
    valid_d  = valid_q;
    per_d    = per_q;
    high_d   = high_q;
    ovr_d    = ovr_q;
    sticky_d = sticky_q;
    if (form_q) begin
      if (!valid_q || meas_ready) begin
        valid_d  = 1'b1;
        per_d    = fper_q;
        high_d   = fhi_q;
        ovr_d    = sticky_q;
        sticky_d = 1'b0;
      end else begin
        sticky_d = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      sdly_q    <= 1'b0;
      arm_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      hi_seen_q <= 1'b0;
      timeout_q <= 1'b0;
      form_q    <= 1'b0;
      fper_q    <= '0;
      fhi_q     <= '0;
      valid_q   <= 1'b0;
      per_q     <= '0;
      high_q    <= '0;
      ovr_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sdly_q    <= s_s;
      arm_q     <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      hi_seen_q <= hi_seen_d;
      timeout_q <= timeout_d;
      form_q    <= form_d;
      fper_q    <= fper_d;
      fhi_q     <= fhi_d;
      valid_q   <= valid_d;
      per_q     <= per_d;
      high_q    <= high_d;
      ovr_q     <= ovr_d;
      sticky_q  <= sticky_d;
    end
  end

  assign meas_valid = valid_q;
  assign period     = per_q;
  assign high_time  = high_q;
  assign overrun    = ovr_q;
  assign timeout    = timeout_q;

endmodule
